// File: rtl/ah_cpu2pl_intr_sched.sv
// ah_cpu2pl_intr_sched: latches per-channel event pulses and dispatches them round-robin over valid/ready
//   Ports: S_AXI_ACLK/S_AXI_ARESETN clock and async active-low reset; intr_in event pulses;
//   intr_busy registered backpressure; out_valid/out_channel/out_ready dispatch handshake;
//   pending bitmap; overrun sticky lost-event flags with overrun_clr; timeout_flag sticky watchdog.
//   Optional watchdog enabled by defining AH_CPU2PL_SCHED_TIMEOUT_EN.
module ah_cpu2pl_intr_sched #(
    parameter int USED_OUTPUTS   = 4,
    parameter int BUSY_THRESHOLD = USED_OUTPUTS,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CH_W = (USED_OUTPUTS > 1) ? $clog2(USED_OUTPUTS) : 1
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [USED_OUTPUTS-1:0] intr_in,
    output logic                    intr_busy,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_channel,
    input  logic                    out_ready,
    output logic [USED_OUTPUTS-1:0] pending,
    output logic [USED_OUTPUTS-1:0] overrun,
    input  logic                    overrun_clr,
    output logic                    timeout_flag
);
    typedef enum logic {IDLE, DISPATCH} state_t;
    state_t                  r_state;
    logic [USED_OUTPUTS-1:0] r_pending;
    logic [USED_OUTPUTS-1:0] r_overrun;
    logic                    r_busy;
    logic                    r_valid;
    logic [CH_W-1:0]         r_chan;
    logic [CH_W-1:0]         r_ptr;
    logic                    w_tmo;
    logic                    w_acc;
    logic [USED_OUTPUTS-1:0] w_clr;
    logic [USED_OUTPUTS-1:0] w_pend_next;
    logic [USED_OUTPUTS-1:0] w_ovr_set;
    logic [CH_W-1:0]         w_sel;
    logic                    w_found;
    logic [CH_W-1:0]         w_ptr_next;
    int                      w_idx;
    int                      w_cnt;

    assign w_acc       = (r_state == DISPATCH) && (out_ready || w_tmo);
    assign w_clr       = w_acc ? (USED_OUTPUTS'(1) << r_chan) : '0;
    // A pulse on a channel being cleared this cycle re-arms it without counting as lost.
    assign w_pend_next = (r_pending & ~w_clr) | intr_in;
    assign w_ovr_set   = intr_in & r_pending & ~w_clr;
    assign w_ptr_next  = (int'(r_chan) == USED_OUTPUTS - 1) ? '0 : r_chan + 1'b1;

    // First pending channel at or after the pointer, wrapping.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < USED_OUTPUTS; i++) begin
            w_idx = (int'(r_ptr) + i) % USED_OUTPUTS;
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_sel   = CH_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_cnt = 0;
        for (int i = 0; i < USED_OUTPUTS; i++) w_cnt += int'(w_pend_next[i]);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_overrun <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_chan    <= '0;
            r_ptr     <= '0;
        end else begin
            r_pending <= w_pend_next;
            r_overrun <= (overrun_clr ? '0 : r_overrun) | w_ovr_set;
            r_busy    <= w_cnt >= BUSY_THRESHOLD;
            if (r_state == IDLE) begin
                if (w_found) begin
                    r_chan  <= w_sel;
                    r_valid <= 1'b1;
                    r_state <= DISPATCH;
                end
            end else if (w_acc) begin
                r_ptr   <= w_ptr_next;
                r_valid <= 1'b0;
                r_state <= IDLE;
            end
        end
    end

`ifdef AH_CPU2PL_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_tflag;

    // Counter restarts every time IDLE is visited, so it measures the current offer only.
    assign w_tmo = (r_state == DISPATCH) && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_tcnt  <= '0;
            r_tflag <= 1'b0;
        end else begin
            r_tcnt  <= (r_state == IDLE || w_acc) ? '0 : r_tcnt + 1'b1;
            r_tflag <= (r_tflag & ~overrun_clr) | (w_tmo & ~out_ready);
        end
    end

    assign timeout_flag = r_tflag;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign w_tmo        = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign intr_busy   = r_busy;
    assign out_valid   = r_valid;
    assign out_channel = r_chan;
    assign pending     = r_pending;
    assign overrun     = r_overrun;
endmodule

// File: doc/ah_cpu2pl_intr_sched.md
# ah_cpu2pl_intr_sched

Interrupt scheduler for the CPU-to-PL register bank. It collects the per-register write-completion pulses (`intr_output`) from the AXI-lite write-register block and latches them as pending events. It dispatches the events one at a time, round-robin, to a single PL consumer over a valid/ready handshake. It drives the bank's `intr_busy` input to stall further AXI writes while too many events are outstanding.

## Interface
Parameters:
- `USED_OUTPUTS`, default 4: number of channels (register slots); legal range 1..32.
- `BUSY_THRESHOLD`, default `USED_OUTPUTS`: pending count at or above which `intr_busy` asserts; legal range 1..`USED_OUTPUTS`.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit; used only with `AH_CPU2PL_SCHED_TIMEOUT_EN`.
- `CH_W`, derived (not overridable): `max(1, $clog2(USED_OUTPUTS))`.

Ports:
- `S_AXI_ACLK` in 1: the single clock.
- `S_AXI_ARESETN` in 1: asynchronous active-low reset.
- `intr_in` in `USED_OUTPUTS`: event pulses, one bit per channel; several bits may be set in one cycle.
- `intr_busy` out 1: registered backpressure to the register bank.
- `out_valid` out 1: a dispatch is offered.
- `out_channel` out `CH_W`: channel index of the offered dispatch; stable while `out_valid` is high.
- `out_ready` in 1: consumer accepts the dispatch.
- `pending` out `USED_OUTPUTS`: pending-event bitmap (registered).
- `overrun` out `USED_OUTPUTS`: sticky per-channel lost-event flags.
- `overrun_clr` in 1: synchronous clear of all `overrun` bits.
- `timeout_flag` out 1: sticky watchdog flag; tied to 0 when the watchdog is compiled out.

## Operation
- Reset values: `pending`=0, `overrun`=0, `intr_busy`=0, `out_valid`=0, `out_channel`=0, `timeout_flag`=0, round-robin pointer=0, state=IDLE.
- Event capture: when `intr_in[i]`=1, `pending[i]` is set next cycle.
  - If `pending[i]` is already 1 and is not being cleared in the same cycle, `overrun[i]` is set instead; the event is merged into the existing pending bit.
  - If `pending[i]` is cleared by an accept in the same cycle as a new pulse on channel i, `pending[i]` stays 1 and no overrun is flagged.
- `overrun_clr` clears all overrun bits. If it coincides with a new overrun event, the set wins.
- FSM states:
  - IDLE: if `pending`≠0, select the first set bit at or after the pointer, wrapping at `USED_OUTPUTS`-1 to 0. Register that index to `out_channel`, set `out_valid`, go to DISPATCH. If `pending`=0, stay in IDLE.
  - DISPATCH: hold `out_valid` and `out_channel`. On `out_ready`, clear `pending[out_channel]`, set pointer to `out_channel`+1 (mod `USED_OUTPUTS`), drop `out_valid`, and return to IDLE.
- `intr_busy` is registered: `intr_busy` = (popcount of next-cycle `pending`) ≥ `BUSY_THRESHOLD`.
- Asserting reset mid-dispatch drops the offer immediately (asynchronously). All pending events are lost.

## Timing
- `intr_in` pulse at cycle t: `pending` bit visible at t+1. Earliest `out_valid` at t+2 (IDLE samples `pending` at t+1).
- Accept at cycle a (`out_valid` && `out_ready`): `out_valid`=0 at a+1. The next dispatch is offered no earlier than a+2. Maximum throughput is one dispatch per 2 cycles.
- `intr_busy` follows `pending` with the same registered timing: it is valid at t+1 for a pulse at t. This is sufficient because the register bank issues `intr_output` at least 2 cycles after it accepts a write.
- `out_ready` held constantly high: the channel is dispatched and cleared in the first DISPATCH cycle.

## Configuration
- `AH_CPU2PL_SCHED_TIMEOUT_EN` defined:
  - A counter runs in DISPATCH and resets on entry.
  - If `out_ready` has not been seen after `TIMEOUT_CYCLES` cycles in DISPATCH, the offer is treated as accepted: the pending bit is cleared, the pointer advances, `timeout_flag` is set sticky, and the FSM returns to IDLE.
  - `timeout_flag` is cleared by `overrun_clr`.
- Not defined: no counter is instantiated; `timeout_flag` is constant 0; DISPATCH waits indefinitely.

## Test plan
- Single event: pulse `intr_in`=4'b0100, `out_ready`=1 → `pending`=0100 next cycle; `out_valid`=1 with `out_channel`=2 two cycles after the pulse; `pending`=0 after the accept.
- Round-robin: pulse `intr_in`=4'b1111 in one cycle, `out_ready`=1 → dispatch order 0,1,2,3 at 2-cycle spacing. A second burst with the pointer at 2 (channels 0 and 3 pending) → order 3,0.
- Backpressure: `BUSY_THRESHOLD`=2, `out_ready`=0, pulse channel 0 then channel 1 → `intr_busy`=1 the cycle after the second pulse. Raise `out_ready` → `intr_busy`=0 the cycle after the first accept.
- Overrun and coincidence:
  - Pulse channel 1 twice while `out_ready`=0 → `overrun`=0010.
  - Pulse channel 1 in the accept cycle of channel 1 → `pending[1]` stays 1 and `overrun` is unchanged.
  - `overrun_clr` → `overrun`=0.
- Timeout (macro defined, `TIMEOUT_CYCLES`=8): one event with `out_ready`=0 → after 8 DISPATCH cycles, `out_valid`=0, `pending`=0, `timeout_flag`=1. With the macro undefined, `out_valid` stays 1 for more than 100 cycles.
- Reset mid-dispatch: assert `S_AXI_ARESETN`=0 while `out_valid`=1 → all outputs at reset values before the next clock edge.
